// File: rtl/bp_pkg.sv
// Shared encodings and helpers for the branch predictor: 2-bit counter states,
// predictor mode selectors and the saturating counter step.
package bp_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam int BP_BIMODAL = 0;
    localparam int BP_GSHARE  = 1;

    // Step a 2-bit counter toward the resolved direction, clamping at SNT/ST.
    function automatic logic [1:0] sat2_next(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (cnt == ST) ? ST : cnt + 2'd1;
        end else begin
            nxt = (cnt == SNT) ? SNT : cnt - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bp_pht.sv
// Pattern history table: 2^IDX_W flop-based 2-bit counters with one
// combinational read port and one registered read-modify-write training port.
module bp_pht
    import bp_pkg::*;
#(
    parameter int         IDX_W    = 10,
    parameter logic [1:0] INIT_CNT = WNT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [1:0]       rd_cnt_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic             wr_taken_i
);

    localparam int ENTRIES = 2 ** IDX_W;

    logic [1:0] mem_q [ENTRIES];

    // Reads see the pre-update value when they hit the entry being trained.
    assign rd_cnt_o = mem_q[rd_idx_i];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem_q[i] <= INIT_CNT;
            end
        end else if (wr_en_i) begin
            mem_q[wr_idx_i] <= sat2_next(mem_q[wr_idx_i], wr_taken_i);
        end
    end

endmodule

// File: rtl/branch_predictor_gshare.sv
// D-stage branch predictor (bimodal or gshare) with a speculative global
// history register repaired from M-stage resolution, plus saturating perf counters.
module branch_predictor_gshare
    import bp_pkg::*;
#(
    parameter int         PHT_IDX_W = 10,
    parameter int         GHR_W     = 8,
    parameter int         MODE      = BP_GSHARE,
    parameter logic [1:0] INIT_CNT  = WNT,
    parameter int         PERF_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pred_req_i,
    input  logic [31:0]          pred_pc_i,
    input  logic                 pred_stall_i,
    input  logic                 pred_flush_i,
    output logic                 pred_take_o,
    output logic [PHT_IDX_W-1:0] pred_idx_o,
    output logic [GHR_W-1:0]     pred_ghr_o,
    input  logic                 upd_valid_i,
    input  logic [PHT_IDX_W-1:0] upd_idx_i,
    input  logic [GHR_W-1:0]     upd_ghr_i,
    input  logic                 upd_taken_i,
    input  logic                 upd_mispredict_i,
    output logic [PERF_W-1:0]    perf_branch_o,
    output logic [PERF_W-1:0]    perf_miss_o
);

    logic [GHR_W-1:0]     ghr_q, ghr_d;
    logic [GHR_W-1:0]     ghr_repair, ghr_shift;
    logic [PHT_IDX_W-1:0] pc_idx, ghr_ext, idx;
    logic [1:0]           rd_cnt;
    logic [PERF_W-1:0]    perf_branch_q, perf_branch_d;
    logic [PERF_W-1:0]    perf_miss_q, perf_miss_d;
    logic                 miss;
    logic                 unused_pc;

    assign unused_pc = ^{pred_pc_i[31:PHT_IDX_W+2], pred_pc_i[1:0]};

    assign pc_idx  = pred_pc_i[PHT_IDX_W+1:2];
    assign ghr_ext = PHT_IDX_W'(ghr_q);
    assign idx     = (MODE == BP_GSHARE) ? (pc_idx ^ ghr_ext) : pc_idx;

    bp_pht #(
        .IDX_W    (PHT_IDX_W),
        .INIT_CNT (INIT_CNT)
    ) u_pht (
        .clk        (clk),
        .rst        (rst),
        .rd_idx_i   (idx),
        .rd_cnt_o   (rd_cnt),
        .wr_en_i    (upd_valid_i),
        .wr_idx_i   (upd_idx_i),
        .wr_taken_i (upd_taken_i)
    );

    assign pred_take_o = rd_cnt[1];
    assign pred_idx_o  = idx;
    assign pred_ghr_o  = ghr_q;

    // A one-bit history has nothing to shift; the new outcome simply replaces it.
    if (GHR_W == 1) begin : g_ghr1
        logic unused_upd_ghr;
        assign unused_upd_ghr = upd_ghr_i[0];
        assign ghr_repair     = upd_taken_i;
        assign ghr_shift      = pred_take_o;
    end else begin : g_ghrn
        logic unused_upd_ghr;
        assign unused_upd_ghr = upd_ghr_i[GHR_W-1];
        assign ghr_repair     = {upd_ghr_i[GHR_W-2:0], upd_taken_i};
        assign ghr_shift      = {ghr_q[GHR_W-2:0], pred_take_o};
    end

    assign miss = upd_valid_i & upd_mispredict_i;

    // Repair wins over the D-stage shift: that D-stage branch is on the wrong path.
    always_comb begin
        ghr_d = ghr_q;
        if (miss) begin
            ghr_d = ghr_repair;
        end else if (pred_req_i && !pred_stall_i && !pred_flush_i) begin
            ghr_d = ghr_shift;
        end
    end

    always_comb begin
        perf_branch_d = perf_branch_q;
        perf_miss_d   = perf_miss_q;
        if (upd_valid_i && (perf_branch_q != '1)) begin
            perf_branch_d = perf_branch_q + 1'b1;
        end
        if (miss && (perf_miss_q != '1)) begin
            perf_miss_d = perf_miss_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_q         <= '0;
            perf_branch_q <= '0;
            perf_miss_q   <= '0;
        end else begin
            ghr_q         <= ghr_d;
            perf_branch_q <= perf_branch_d;
            perf_miss_q   <= perf_miss_d;
        end
    end

    assign perf_branch_o = perf_branch_q;
    assign perf_miss_o   = perf_miss_q;

endmodule

// File: doc/branch_predictor_gshare.md
Name: branch_predictor_gshare

Overview:
- Parametrised successor to the per-PC 2-bit predictor used in the 5-stage MIPS pipeline.
- Adds a selectable mode: bimodal, or gshare with global history.
- Keeps a speculative global history register (GHR) and repairs it on mispredict.
- Adds saturating performance counters.
- Predicts in the D stage. Trains from M-stage resolution (branchM / actual_takeM / pred_takeM).
- D stage must carry the pred_idx_o / pred_ghr_o tags down the pipeline to M.

Parameters:
- PHT_IDX_W, 10, log2 of pattern-history-table entries (1024 x 2-bit counters).
- GHR_W, 8, global history length; legal range 1..PHT_IDX_W.
- MODE, 1, 0 = bimodal (index = PC only), 1 = gshare (index = PC xor GHR).
- INIT_CNT, 2'b01, reset value of every PHT counter (weakly not-taken).
- PERF_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- pred_req_i  in  1  D stage holds a branch instruction (branchD)
- pred_pc_i  in  32  pcD
- pred_stall_i  in  1  stallD
- pred_flush_i  in  1  flushD
- pred_take_o  out  1  prediction for pred_pc_i (combinational)
- pred_idx_o  out  PHT_IDX_W  PHT index used; carried down the pipeline
- pred_ghr_o  out  GHR_W  speculative GHR before this branch's shift; carried down the pipeline
- upd_valid_i  in  1  M stage resolves a branch (branchM & ~stallM)
- upd_idx_i  in  PHT_IDX_W  carried pred_idx
- upd_ghr_i  in  GHR_W  carried pred_ghr
- upd_taken_i  in  1  actual_takeM
- upd_mispredict_i  in  1  flush_pred_failedM, qualified by upd_valid_i
- perf_branch_o  out  PERF_W  resolved-branch count
- perf_miss_o  out  PERF_W  mispredict count

Behaviour:
- Reset (rst high at clk edge, overrides all other inputs):
  - all PHT counters = INIT_CNT
  - spec GHR = 0
  - perf counters = 0
  - reset applied mid-operation discards any in-flight update in that cycle.
- Index:
  - MODE 0: idx = pc[PHT_IDX_W+1:2]
  - MODE 1: idx = pc[PHT_IDX_W+1:2] ^ zero-extend(spec_ghr)
  - pc[1:0] is ignored.
- Prediction:
  - pred_take_o = PHT[idx][1], combinational, zero latency.
  - pred_idx_o = idx; pred_ghr_o = spec_ghr.
  - Outputs are meaningful only when pred_req_i = 1.
- Counter update (registered, 1-cycle):
  - when upd_valid_i: PHT[upd_idx_i] +1 if taken, else -1, saturating at 00/11.
  - A same-cycle read of the same index returns the pre-update value; no bypass.
- GHR, evaluated in priority order:
  1. upd_valid_i & upd_mispredict_i: spec_ghr <= {upd_ghr_i[GHR_W-2:0], upd_taken_i}. The D-stage branch is being flushed and does not shift.
  2. pred_req_i & ~pred_stall_i & ~pred_flush_i: spec_ghr <= {spec_ghr[GHR_W-2:0], pred_take_o}.
  3. otherwise hold.
  - GHR_W = 1: the shift degenerates to a plain assignment.
  - In MODE 0 the GHR is still maintained but is not used for indexing.
- Perf counters:
  - perf_branch_o +1 on each upd_valid_i.
  - perf_miss_o +1 on each upd_valid_i & upd_mispredict_i.
  - both saturate at all-ones; no wrap.
- An upd_mispredict_i without upd_valid_i is ignored.

Decomposition:
- Package bp_pkg:
  - counter encodings SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11
  - mode constants BP_BIMODAL = 0, BP_GSHARE = 1
  - function sat2_next(cnt, taken)
- Sub-module bp_pht:
  - flop-based 2^PHT_IDX_W x 2 table
  - one async read port, one sync write port
  - synchronous reset to INIT_CNT
- The top level holds index hashing, GHR control and perf counters.

Test Plan:
1. Reset, then pred_req_i with pc 0xbfc00010 (PHT_IDX_W = 4, MODE 0) -> pred_idx_o = 4, pred_take_o = 0, pred_ghr_o = 0, both perf counters = 0.
2. Three upd_valid_i, taken = 1, idx 4 -> counter 01→10→11→11; pred_take_o = 1 from the first update onward; one not-taken update -> 10, still taken; perf_branch_o = 4.
3. MODE 1, GHR_W = 4: three unstalled pred_req_i with pred_take_o forced 1 via pretrained counters -> spec_ghr 0000→0001→0011→0111, and pred_idx_o changes with the GHR for the same pc.
4. Same cycle: upd_mispredict_i with upd_ghr_i = 4'b0011, upd_taken_i = 0, plus an unstalled pred_req_i -> spec_ghr = 4'b0110, no D-stage shift; perf_miss_o +1.
5. pred_stall_i or pred_flush_i high with pred_req_i -> spec_ghr unchanged over 5 cycles; counters unchanged.
6. Preload perf_miss_o near all-ones (PERF_W = 4), issue 3 mispredicts -> holds 4'hF. Then assert rst during an upd_valid_i -> all counters INIT_CNT, GHR 0, perf 0 next cycle.
